hazard_fwd_unit: RTL

- Parametrised successor to the combinational forwarding unit in the pipelined RV32I core.
- Owns an internal destination tracker: a shift register mirroring the EX..WB stages.
- Produces per-read-port forwarding selects and a load-use stall, and inserts the bubble itself.
- Generalised in read-port count, forwarding depth and load-data availability stage.

---
 rtl/titan_hazard_pkg.sv | 29 ++
 rtl/hazard_port_match.sv | 41 ++++
 rtl/hazard_fwd_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/titan_hazard_pkg.sv
// rtl/titan_hazard_pkg.sv - shared types and constants for the hazard/forwarding unit
// Contents: trk_entry_t (one tracker entry at the default 5-bit register
// address width), forwarding-select codes and the select-width helper.
// The tracker itself is stored flattened so REG_AW can vary; each entry keeps
// the same field order as trk_entry_t: {v, we, ld, rd}.
package titan_hazard_pkg;

   localparam int TRK_RD_W = 5;

   typedef struct packed {
      logic                v;
      logic                we;
      logic                ld;
      logic [TRK_RD_W-1:0] rd;
   } trk_entry_t;

   localparam int SEL_RF  = 0;
   localparam int SEL_EX  = 1;
   localparam int SEL_MEM = 2;
   localparam int SEL_WB  = 3;

   // Status fields per entry on top of rd: v, we, ld.
   localparam int TRK_META_W = 3;

   function automatic int f_sel_w(input int nstages);
      return $clog2(nstages + 1);
   endfunction

endpackage

// File: rtl/hazard_port_match.sv
// rtl/hazard_port_match.sv - youngest-match search for one source read port
// Ports:
//   trk_i      flattened tracker, entry k (1-based) at [(k-1)*TW +: TW], TW = REG_AW+3
//   rs_i       source register address of this port
//   used_i     this port actually reads rs_i
//   sel_o      youngest matching stage (0 = register file)
//   ld_young_o youngest match is a load that is not yet forwardable
module hazard_port_match
   import titan_hazard_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int NSTAGES    = 3,
   parameter int LOAD_STAGE = 2,
   parameter int SEL_W      = 2
) (
   input  logic [NSTAGES*(REG_AW+TRK_META_W)-1:0] trk_i,
   input  logic [REG_AW-1:0]                      rs_i,
   input  logic                                   used_i,
   output logic [SEL_W-1:0]                       sel_o,
   output logic                                   ld_young_o
);

   localparam int TW = REG_AW + TRK_META_W;

   logic [TW-1:0] e;

   // Scan oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      sel_o      = SEL_W'(SEL_RF);
      ld_young_o = 1'b0;
      e          = '0;
      for (int k = NSTAGES; k >= 1; k--) begin
         e = trk_i[(k-1)*TW +: TW];
         if (used_i && (rs_i != '0) && e[TW-1] && e[TW-2] && (e[REG_AW-1:0] == rs_i)) begin
            sel_o      = SEL_W'(k);
            ld_young_o = e[REG_AW] && (k < LOAD_STAGE);
         end
      end
   end

endmodule

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - destination tracker, operand forwarding selects and load-use stall
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   id_valid_i        valid instruction in ID
//   id_rs_i           NRP source addresses, port p at [p*REG_AW +: REG_AW]
//   id_rs_used_i      per-port "really reads rs"
//   id_rd_i, id_we_i  destination of the ID instruction and its write enable
//   id_load_i         ID instruction is a load
//   hold_i            global freeze, flush_i kills the instruction leaving ID
//   fwd_sel_o         per port, 0 = register file, k = tracked stage k
//   stall_o           load-use stall (holds PC/ID)
//   ex_rd_o           debug copy of entry[1].rd
//   stall_cnt_o       stall cycle counter, present only with HAZARD_PERF_CNT_EN
module hazard_fwd_unit
   import titan_hazard_pkg::*;
#(
   parameter  int REG_AW     = 5,
   parameter  int NRP        = 2,
   parameter  int NSTAGES    = 3,
   parameter  int LOAD_STAGE = 2,
   localparam int SEL_W      = f_sel_w(NSTAGES)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  id_valid_i,
   input  logic [NRP*REG_AW-1:0] id_rs_i,
   input  logic [NRP-1:0]        id_rs_used_i,
   input  logic [REG_AW-1:0]     id_rd_i,
   input  logic                  id_we_i,
   input  logic                  id_load_i,
   input  logic                  hold_i,
   input  logic                  flush_i,
   output logic [NRP*SEL_W-1:0]  fwd_sel_o,
   output logic                  stall_o,
   output logic [REG_AW-1:0]     ex_rd_o
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]           stall_cnt_o
`endif
);

   localparam int TW = REG_AW + TRK_META_W;

   logic [NSTAGES*TW-1:0] trk_q;
   logic [NSTAGES*TW-1:0] trk_adv;
   logic [TW-1:0]         new_e;
   logic [NRP-1:0]        ld_young;
   logic [NRP*SEL_W-1:0]  sel_raw;

   for (genvar p = 0; p < NRP; p++) begin : g_port
      hazard_port_match #(
         .REG_AW     (REG_AW),
         .NSTAGES    (NSTAGES),
         .LOAD_STAGE (LOAD_STAGE),
         .SEL_W      (SEL_W)
      ) u_match (
         .trk_i      (trk_q),
         .rs_i       (id_rs_i[p*REG_AW +: REG_AW]),
         .used_i     (id_rs_used_i[p]),
         .sel_o      (sel_raw[p*SEL_W +: SEL_W]),
         .ld_young_o (ld_young[p])
      );
   end

   assign stall_o   = id_valid_i & ~flush_i & ~hold_i & (|ld_young);
   assign fwd_sel_o = stall_o ? '0 : sel_raw;
   assign ex_rd_o   = trk_q[REG_AW-1:0];

   // A stalled or flushed ID slot enters as an all-zero bubble; writes to x0
   // are recorded with we = 0 so they can never be forwarded.
   always_comb begin
      new_e = '0;
      if (id_valid_i && !stall_o && !flush_i) begin
         new_e = {1'b1, id_we_i && (id_rd_i != '0), id_load_i, id_rd_i};
      end
      trk_adv          = trk_q << TW;
      trk_adv[TW-1:0]  = new_e;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         trk_q <= '0;
      end else if (hold_i) begin
         if (flush_i) begin
            trk_q[TW-1] <= 1'b0;
         end
      end else begin
         trk_q <= trk_adv;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // stall_o is already low during hold, so the count freezes with the pipe.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_o <= '0;
      end else if (!hold_i && stall_o) begin
         stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule
